// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding, default HD44780 timing and accumulator width
package lcd_pkg;
  localparam int ACC_W       = 12;
  localparam int T_AS_NS_DEF = 40;
  localparam int T_EH_NS_DEF = 240;
  localparam int T_EL_NS_DEF = 260;
  typedef enum logic [2:0] {IDLE, SETUP, E_HI1, E_LO1, E_HI2, E_LO2, DONE} lcd_state_e;
endpackage

// File: rtl/lcd_ns_timer.sv
// lcd_ns_timer: per-state ns accumulator; expire once target ns have elapsed
module lcd_ns_timer
  import lcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       period,
  input  logic [ACC_W-1:0] target,
  input  logic             clear,
  output logic             expire
);
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;
  assign sum    = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, period};
  assign expire = sum >= {1'b0, target};
  // saturate so an idle accumulator never wraps back under target
  always_comb acc_d = clear ? '0 : sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  always_ff @(posedge clk or negedge rst)
    if (!rst) acc_q <= '0;
    else acc_q <= acc_d;
endmodule

// File: rtl/lcd_reader.sv
// lcd_reader: 4-bit HD44780 read cycles (busy/address or data) with optional busy polling
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int T_AS_NS   = T_AS_NS_DEF,
  parameter int T_EH_NS   = T_EH_NS_DEF,
  parameter int T_EL_NS   = T_EL_NS_DEF,
  parameter int MAX_POLLS = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs_in,
  input  logic       poll_in,
  input  logic       strobe_in,
  input  logic [7:0] period_clk_ns,
  input  logic [3:0] lcd_nibble_in,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_drive_en,
  output logic       disable_flash,
  output logic [7:0] data_out,
  output logic       busy_flag,
  output logic       done,
  output logic       timeout
);
  localparam int PW = $clog2(MAX_POLLS + 1) + 1;
  localparam logic [ACC_W-1:0] T_AS = ACC_W'(T_AS_NS);
  localparam logic [ACC_W-1:0] T_EH = ACC_W'(T_EH_NS);
  localparam logic [ACC_W-1:0] T_EL = ACC_W'(T_EL_NS);
  lcd_state_e       state_q, state_d;
  logic             rs_q, rs_d, poll_q, poll_d;
  logic [7:0]       period_q, period_d, data_q, data_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
  logic             lcd_e_q, lcd_e_d, lcd_rs_q, lcd_rs_d, lcd_rw_q, lcd_rw_d;
  logic [ACC_W-1:0] target;
  logic             clear, expire;
  assign target = (state_q == SETUP) ? T_AS : (state_q == E_HI1 || state_q == E_HI2) ? T_EH : T_EL;
  assign clear  = state_d != state_q;
  lcd_ns_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .period (period_q),
    .target (target),
    .clear  (clear),
    .expire (expire)
  );
  always_comb begin
    state_d  = state_q;
    rs_d     = rs_q;
    poll_d   = poll_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (strobe_in) begin
          rs_d     = rs_in;
          poll_d   = poll_in & ~rs_in;
          period_d = (period_clk_ns == 8'd0) ? 8'd1 : period_clk_ns;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = expire ? E_HI1 : SETUP;
      E_HI1: if (expire) begin
        data_d[7:4] = lcd_nibble_in;
        state_d     = E_LO1;
      end
      E_LO1: state_d = expire ? E_HI2 : E_LO1;
      E_HI2: if (expire) begin
        data_d[3:0] = lcd_nibble_in;
        state_d     = E_LO2;
      end
      E_LO2: if (expire) begin
        if (poll_q && data_q[7] && cnt_q < PW'(MAX_POLLS)) begin
          cnt_d   = cnt_q + PW'(1);
          state_d = E_HI1;
        end else state_d = DONE;
      end
      DONE: begin
        busy_d  = rs_q ? busy_q : data_q[7];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // pin outputs follow the next state so they line up with the state they belong to
    lcd_e_d   = state_d == E_HI1 || state_d == E_HI2;
    lcd_rw_d  = state_d != IDLE;
    lcd_rs_d  = lcd_rw_d & rs_d;
    done_d    = state_q == DONE;
    timeout_d = state_q == DONE && poll_q && data_q[7];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= IDLE;
      rs_q      <= 1'b0;
      poll_q    <= 1'b0;
      period_q  <= 8'd1;
      cnt_q     <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      lcd_e_q   <= 1'b0;
      lcd_rs_q  <= 1'b0;
      lcd_rw_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rs_q      <= rs_d;
      poll_q    <= poll_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      lcd_e_q   <= lcd_e_d;
      lcd_rs_q  <= lcd_rs_d;
      lcd_rw_q  <= lcd_rw_d;
    end
  assign lcd_e         = lcd_e_q;
  assign lcd_rs        = lcd_rs_q;
  assign lcd_rw        = lcd_rw_q;
  assign lcd_drive_en  = 1'b0;
  assign disable_flash = 1'b1;
  assign data_out      = data_q;
  assign busy_flag     = busy_q;
  assign done          = done_q;
  assign timeout       = timeout_q;
endmodule

// File: tb/tb_lcd_reader.sv
// tb_lcd_reader: directed and random read transactions against an arithmetic timing/bus model
module tb_lcd_reader;
  logic       clk = 0, rst = 0, rs_in = 0, poll_in = 0, strobe_in = 0;
  logic [7:0] period_clk_ns = 8'd20;
  logic [3:0] bus_nib = 4'h0;
  logic [1:0] e, rso, rw, den, dfl, dn, to, bsy;
  logic [7:0] dat [2];
  bit         sel = 0;
  logic [7:0] resp [8];
  int         ridx = 0, dly = 160, n_chk = 0, n_fail = 0;
  bit         half = 0;
  logic       bm = 0;

  always #10 clk = ~clk;

  lcd_reader dut (
    .clk(clk), .rst(rst), .rs_in(rs_in), .poll_in(poll_in), .strobe_in(strobe_in),
    .period_clk_ns(period_clk_ns), .lcd_nibble_in(bus_nib), .lcd_e(e[0]), .lcd_rs(rso[0]),
    .lcd_rw(rw[0]), .lcd_drive_en(den[0]), .disable_flash(dfl[0]), .data_out(dat[0]),
    .busy_flag(bsy[0]), .done(dn[0]), .timeout(to[0])
  );
  lcd_reader #(.MAX_POLLS(2)) dut2 (
    .clk(clk), .rst(rst), .rs_in(rs_in), .poll_in(poll_in), .strobe_in(strobe_in),
    .period_clk_ns(period_clk_ns), .lcd_nibble_in(bus_nib), .lcd_e(e[1]), .lcd_rs(rso[1]),
    .lcd_rw(rw[1]), .lcd_drive_en(den[1]), .disable_flash(dfl[1]), .data_out(dat[1]),
    .busy_flag(bsy[1]), .done(dn[1]), .timeout(to[1])
  );

  // LCD bus model: each E rise returns the next nibble (high then low) after the access delay
  always @(posedge e[sel]) begin
    int d;
    d = dly;
    #(d);
    if (rst) begin
      bus_nib = half ? resp[ridx][3:0] : resp[ridx][7:4];
      if (half && ridx < 7) ridx++;
      half = ~half;
    end
  end

  function automatic int cyc(input int t, input int p);
    return (t + p - 1) / p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    resp[0] = b0; resp[1] = b1; resp[2] = b2;
    for (int i = 3; i < 8; i++) resp[i] = b3;
    ridx = 0;
    half = 0;
  endtask

  task automatic run(input string nm, input bit s, input logic r, input logic p, input logic [7:0] per,
                     input logic [7:0] per_after, input int reads, input logic [7:0] exp_data,
                     input logic exp_to, input int pulse_at);
    int pp, ceh, lat, n, ehi;
    bit got, rw_ok, rs_ok;
    logic exp_busy;
    pp  = (per == 0) ? 1 : int'(per);
    ceh = cyc(240, pp);
    lat = cyc(40, pp) + reads * (2 * ceh + 2 * cyc(260, pp)) + 1;
    dly = (ceh * 20 > 170) ? 160 : ceh * 20 - 10;
    exp_busy = r ? bm : exp_data[7];
    sel = s;
    @(negedge clk);
    rs_in = r; poll_in = p; period_clk_ns = per; strobe_in = 1;
    @(posedge clk); #1;
    strobe_in = 0; period_clk_ns = per_after; rs_in = 1'($urandom); poll_in = 1'($urandom);
    rw_ok = rw[sel] === 1'b1;
    rs_ok = rso[sel] === r;
    n = 0; got = 0; ehi = 0;
    while (!got && n < lat + 20) begin
      @(posedge clk); #1;
      n++;
      strobe_in = (n == pulse_at);
      if (dn[sel]) got = 1;
      else begin
        rw_ok &= rw[sel] === 1'b1;
        rs_ok &= rso[sel] === r;
        ehi += int'(e[sel]);
      end
    end
    strobe_in = 0;
    chk($sformatf("%s.done_seen", nm), 32'(got), 32'd1);
    chk($sformatf("%s.latency", nm), n, lat);
    chk($sformatf("%s.e_high_cycles", nm), ehi, reads * 2 * ceh);
    chk($sformatf("%s.rw_high", nm), 32'(rw_ok), 32'd1);
    chk($sformatf("%s.rs_held", nm), 32'(rs_ok), 32'd1);
    chk($sformatf("%s.rw_idle", nm), 32'(rw[sel]), 32'd0);
    chk($sformatf("%s.data_out", nm), 32'(dat[sel]), 32'(exp_data));
    chk($sformatf("%s.busy_flag", nm), 32'(bsy[sel]), 32'(exp_busy));
    chk($sformatf("%s.timeout", nm), 32'(to[sel]), 32'(exp_to));
    bm = exp_busy;
  endtask

  initial begin
    int cnt_done, cnt_e;
    logic [7:0] b [4];
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset.outs%0d", i), {e[i], rso[i], rw[i], den[i], dat[i], bsy[i], dn[i], to[i]}, 32'd0);
      chk($sformatf("reset.flash%0d", i), 32'(dfl[i]), 32'd1);
    end
    @(negedge clk) rst = 1;

    load(8'h3A, 8'h3A, 8'h3A, 8'h3A); run("rd_bf", 0, 0, 0, 20, 20, 1, 8'h3A, 0, 0);
    load(8'hC4, 8'hC4, 8'hC4, 8'hC4); run("rd_bf_busy", 0, 0, 0, 20, 20, 1, 8'hC4, 0, 0);
    load(8'h41, 8'h41, 8'h41, 8'h41); run("rd_data", 0, 1, 0, 20, 20, 1, 8'h41, 0, 0);
    load(8'h80, 8'h80, 8'h80, 8'h05); run("poll4", 0, 0, 1, 20, 20, 4, 8'h05, 0, 0);
    load(8'h9E, 8'h9E, 8'h9E, 8'h9E); run("per0", 0, 0, 0, 0, 0, 1, 8'h9E, 0, 0);
    load(8'h27, 8'h27, 8'h27, 8'h27); run("per255", 0, 1, 1, 255, 255, 1, 8'h27, 0, 0);

    for (int t = 0; t < 8; t++) begin
      logic r, p;
      int nb, reads;
      logic [7:0] per;
      r   = 1'($urandom);
      p   = 1'($urandom);
      per = 8'($urandom_range(4, 255));
      nb  = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
      if (p && !r) begin
        for (int i = 0; i < nb; i++) b[i][7] = 1'b1;
        b[nb][7] = 1'b0;
        reads = nb + 1;
      end else reads = 1;
      load(b[0], b[1], b[2], b[3]);
      run($sformatf("rand%0d", t), 0, r, p, per, 8'($urandom), reads, b[reads - 1], 0, 0);
    end

    load(8'h87, 8'h87, 8'h87, 8'h87); run("stuck", 1, 0, 1, 20, 20, 3, 8'h87, 1, 0);
    @(negedge clk) rst = 0;
    repeat (2) @(negedge clk);
    rst = 1; bm = 0;

    load(8'h3A, 8'h3A, 8'h3A, 8'h3A); run("strobe_ign", 0, 0, 0, 20, 20, 1, 8'h3A, 0, 30);
    cnt_done = 0;
    repeat (60) begin
      @(posedge clk); #1;
      cnt_done += int'(dn[0]);
    end
    chk("strobe_ign.extra_done", cnt_done, 0);

    load(8'h55, 8'h55, 8'h55, 8'h55);
    dly = 160; sel = 0;
    @(negedge clk);
    rs_in = 0; poll_in = 0; period_clk_ns = 20; strobe_in = 1;
    @(posedge clk); #1;
    strobe_in = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid.e_before", 32'(e[0]), 32'd1);
    #3 rst = 0;
    #1;
    chk("rst_mid.e_drop", 32'(e[0]), 32'd0);
    chk("rst_mid.outs", {rso[0], rw[0], dat[0], bsy[0], dn[0], to[0]}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1;
    cnt_done = 0; cnt_e = 0;
    repeat (80) begin
      @(posedge clk); #1;
      cnt_done += int'(dn[0]);
      cnt_e += int'(e[0]);
    end
    chk("rst_mid.no_done", cnt_done, 0);
    chk("rst_mid.no_e", cnt_e, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
